// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: request/grant/response data port, lane alignment, load extension.
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise misalign_o instead of aligning down.
module mem_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid_i,
    input  logic            mem_we_i,
    input  logic [1:0]      mem_size_i,
    input  logic            mem_unsigned_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    input  logic [4:0]      rd_i,
    input  logic            rd_we_i,
    input  logic [XLEN-1:0] rd_res_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e state_q, state_d;

    // Captured access, held stable for the whole request/response exchange.
    logic [XLEN-1:2] addr_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            we_q;
    logic [4:0]      rd_q;
    logic            rd_we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;

    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            in_half;
    logic            in_word;
    logic [1:0]      in_off;
    logic [3:0]      in_be;
    logic [XLEN-1:0] in_wdata;
    logic            trap;
    logic            capture;

    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_data;

    // Decode the incoming access; misaligned offsets are aligned down to the access size.
    always_comb begin
        in_half = (mem_size_i == 2'd1);
        in_word = mem_size_i[1];
        in_off  = mem_addr_i[1:0];
        if (in_half) begin
            in_off[0] = 1'b0;
        end
        if (in_word) begin
            in_off = 2'b00;
        end
        if (in_word) begin
            in_be    = 4'hF;
            in_wdata = mem_wdata_i;
        end else if (in_half) begin
            in_be    = 4'b0011 << in_off;
            in_wdata = {2{mem_wdata_i[15:0]}};
        end else begin
            in_be    = 4'b0001 << in_off;
            in_wdata = {4{mem_wdata_i[7:0]}};
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (in_half && mem_addr_i[0]) || (in_word && (mem_addr_i[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign capture = (state_q == StIdle) && mem_valid_i && !trap;

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_shift = dmem_rdata_i >> {off_q, 3'b000};
        if (size_q[1]) begin
            ld_data = dmem_rdata_i;
        end else if (size_q == 2'd1) begin
            ld_data = {{(XLEN-16){~uns_q & ld_shift[15]}}, ld_shift[15:0]};
        end else begin
            ld_data = {{(XLEN-8){~uns_q & ld_shift[7]}}, ld_shift[7:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        stall_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!mem_valid_i) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = rd_we_i;
                    wb_rd_d    = rd_i;
                    wb_data_d  = rd_res_i;
                end else if (!trap) begin
                    state_d = StReq;
                    stall_o = 1'b1;
                end
            end
            StReq: begin
                stall_o = !(we_q && dmem_gnt_i);
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        state_d    = StIdle;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                stall_o = !dmem_rvalid_i;
                if (dmem_rvalid_i) begin
                    state_d    = StIdle;
                    wb_valid_d = 1'b1;
                    wb_we_d    = rd_we_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = ld_data;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            rd_we_q <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            addr_q  <= mem_addr_i[XLEN-1:2];
            off_q   <= in_off;
            size_q  <= mem_size_i;
            uns_q   <= mem_unsigned_i;
            we_q    <= mem_we_i;
            rd_q    <= rd_i;
            rd_we_q <= rd_we_i;
            be_q    <= in_be;
            wdata_q <= in_wdata;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == StIdle) && mem_valid_i && trap;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    // Request fields are gated so the port is quiet outside the request phase.
    assign dmem_req_o   = (state_q == StReq);
    assign dmem_we_o    = dmem_req_o & we_q;
    assign dmem_addr_o  = dmem_req_o ? {addr_q, 2'b00} : '0;
    assign dmem_be_o    = dmem_req_o ? be_q : 4'h0;
    assign dmem_wdata_o = dmem_req_o ? wdata_q : '0;

    assign wb_valid_o = wb_valid_q;
    assign wb_we_o    = wb_we_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;

endmodule
